// File: rtl/signal_count_gen.sv
// rtl/signal_count_gen.sv - rotating lane pattern generator with ramp-up and valid/ready handshake
module signal_count_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] count,
  input  logic       clr,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RAMP, PRESENT} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [2:0] cnt, cnt_n;
  logic [2:0] step, step_n;
  logic [3:0] lanes, lanes_n;
  logic       err_n;
  logic [1:0] sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= 3'd0;
      step  <= 3'd0;
      lanes <= 4'd0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      step  <= step_n;
      lanes <= lanes_n;
      err   <= err_n;
    end
  end

  // Lane to set this edge: rotation start plus number of lanes already set, mod 4.
  assign sel = ptr + step[1:0];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    step_n  = step;
    lanes_n = lanes;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!clr && in_valid) begin
          if (count > 3'd4) begin
            err_n = 1'b1;
          end else begin
            cnt_n   = count;
            step_n  = 3'd0;
            state_n = RAMP;
          end
        end
      end
      RAMP: begin
        if (clr) begin
          lanes_n = 4'd0;
          state_n = IDLE;
        end else if (cnt == 3'd0) begin
          state_n = PRESENT;
        end else begin
          lanes_n[sel] = 1'b1;
          step_n       = step + 3'd1;
          if (step + 3'd1 == cnt) state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (clr) begin
          lanes_n = 4'd0;
          state_n = IDLE;
        end else if (out_ready) begin
          lanes_n = 4'd0;
          ptr_n   = ptr + 2'd1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE);
  assign a         = lanes[0];
  assign b         = lanes[1];
  assign c         = lanes[2];
  assign d         = lanes[3];

endmodule
